// File: rtl/i2c_pkg.sv
// i2c_pkg: command opcodes and bit-master register map for the byte engine.
// Shared by the engine top and its Avalon access helper.
package i2c_pkg;

    typedef enum logic [1:0] {
        OP_START = 2'd0,
        OP_STOP  = 2'd1,
        OP_WRITE = 2'd2,
        OP_READ  = 2'd3
    } op_e;

    localparam logic [3:0] REG_CTRL = 4'd0;
    localparam logic [3:0] REG_GO   = 4'd1;

    localparam int CTRL_BUSY  = 3;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 1;
    localparam int CTRL_DATA  = 0;

    localparam logic [31:0] CTRL_START_CODE = 32'h1 << CTRL_START;
    localparam logic [31:0] CTRL_STOP_CODE  = 32'h1 << CTRL_STOP;

endpackage

// File: rtl/i2c_bus_access.sv
// i2c_bus_access: runs one Avalon-MM access at a time for the engine.
// Holds address/data/strobe through waitrequest, inserts an idle cycle after each access.
module i2c_bus_access
    import i2c_pkg::*;
(
    input  logic        clock,
    input  logic        clock_areset_n,
    input  logic        go,
    input  logic        is_write,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic [3:0]  m_address,
    output logic [31:0] m_writedata,
    output logic        m_read,
    output logic        m_write,
    input  logic [31:0] m_readdata,
    input  logic        m_waitrequest
);

    logic strobe;

    assign strobe = m_read | m_write;

    // Launch on go, hold through stall, complete and drop strobe; done pulses in the idle cycle.
    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            m_address   <= REG_CTRL;
            m_writedata <= 32'd0;
            m_read      <= 1'b0;
            m_write     <= 1'b0;
            done        <= 1'b0;
            rdata       <= 32'd0;
        end else begin
            done <= 1'b0;
            if (strobe) begin
                if (!m_waitrequest) begin
                    m_read  <= 1'b0;
                    m_write <= 1'b0;
                    done    <= 1'b1;
                    rdata   <= m_readdata;
                end
            end else if (go && !done) begin
                m_address   <= addr;
                m_writedata <= wdata;
                m_write     <= is_write;
                m_read      <= !is_write;
            end
        end
    end

endmodule

// File: rtl/i2c_byte_engine.sv
// i2c_byte_engine: byte-level START/STOP/WRITE/READ sequencer over the bit master.
// Optional poll timeout enabled by defining I2C_BYTE_ENGINE_TIMEOUT_EN.
module i2c_byte_engine
    import i2c_pkg::*;
#(
    parameter int GUARD_CYCLES  = 4,
    parameter int TIMEOUT_POLLS = 65535
) (
    input  logic        clock,
    input  logic        clock_areset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_data,
    input  logic        cmd_nack,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_data,
    output logic        rsp_nack,
    output logic        rsp_error,
    output logic [3:0]  m_address,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata,
    output logic        m_read,
    output logic        m_write,
    input  logic        m_waitrequest
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_POLL    = 3'd1;
    localparam logic [2:0] S_SETUP   = 3'd2;
    localparam logic [2:0] S_TRIGGER = 3'd3;
    localparam logic [2:0] S_GUARD   = 3'd4;
    localparam logic [2:0] S_FETCH   = 3'd5;
    localparam logic [2:0] S_ADVANCE = 3'd6;
    localparam logic [2:0] S_RESP    = 3'd7;

    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES + 1) : 1;
    localparam logic [GW-1:0] G_LAST = GW'(GUARD_CYCLES - 1);

    logic [2:0]    state;
    op_e           op;
    logic [7:0]    data;
    logic          nack_req;
    logic [3:0]    bcnt;
    logic [7:0]    shreg;
    logic          wr_nack;
    logic          fetch_pend;
    logic [GW-1:0] gcnt;

    logic          read_bit;
    logic          wr_bit;
    logic          last_bit;
    logic          go;
    logic          is_write;
    logic [3:0]    addr;
    logic [31:0]   wdata;
    logic          done;
    logic [31:0]   rdata;
    logic          busy;
    logic          abort;

    logic          unused_rdata;

    assign unused_rdata = ^{rdata[31:4], rdata[2:1]};
    assign busy = rdata[CTRL_BUSY];

    assign read_bit = (op == OP_WRITE && bcnt[3])
                    || (op == OP_READ && !bcnt[3]);
    assign wr_bit   = (op == OP_WRITE) ? data[~bcnt[2:0]] : nack_req;
    assign last_bit = (op == OP_START) || (op == OP_STOP) || bcnt[3];

    // Avalon request for the current state; the helper sequences the handshake.
    always_comb begin
        go       = 1'b0;
        is_write = 1'b0;
        addr     = REG_CTRL;
        wdata    = 32'd0;
        unique case (state)
            S_POLL, S_FETCH: go = 1'b1;
            S_SETUP: begin
                go       = 1'b1;
                is_write = 1'b1;
                if (op == OP_START) begin
                    wdata = CTRL_START_CODE;
                end else if (op == OP_STOP) begin
                    wdata = CTRL_STOP_CODE;
                end else begin
                    wdata = {31'd0, wr_bit};
                end
            end
            S_TRIGGER: begin
                go       = 1'b1;
                is_write = !read_bit;
                addr     = REG_GO;
            end
            default: go = 1'b0;
        endcase
    end

`ifdef I2C_BYTE_ENGINE_TIMEOUT_EN
    localparam int PW = (TIMEOUT_POLLS > 1) ? $clog2(TIMEOUT_POLLS + 1) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(TIMEOUT_POLLS - 1);

    logic [PW-1:0] pcnt;

    assign abort = (state == S_POLL) && done && busy && (pcnt == P_LAST);

    // Busy-poll counter; zero whenever outside POLL so every entry starts fresh.
    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            pcnt <= '0;
        end else if (state != S_POLL) begin
            pcnt <= '0;
        end else if (done) begin
            pcnt <= pcnt + 1'b1;
        end
    end

    // Error flag raised by a poll timeout, cleared when the response is taken.
    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            rsp_error <= 1'b0;
        end else if (abort) begin
            rsp_error <= 1'b1;
        end else if (state == S_RESP && rsp_ready) begin
            rsp_error <= 1'b0;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT_POLLS;

    assign abort     = 1'b0;
    assign rsp_error = 1'b0;
`endif

    // Command sequencer: bit loop over poll/setup/trigger/guard/fetch.
    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            state      <= S_IDLE;
            cmd_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= 8'd0;
            rsp_nack   <= 1'b0;
            op         <= OP_START;
            data       <= 8'd0;
            nack_req   <= 1'b0;
            bcnt       <= 4'd0;
            shreg      <= 8'd0;
            wr_nack    <= 1'b0;
            fetch_pend <= 1'b0;
            gcnt       <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op         <= op_e'(cmd_op);
                        data       <= cmd_data;
                        nack_req   <= cmd_nack;
                        bcnt       <= 4'd0;
                        shreg      <= 8'd0;
                        wr_nack    <= 1'b0;
                        fetch_pend <= 1'b0;
                        cmd_ready  <= 1'b0;
                        state      <= S_POLL;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                S_POLL: begin
                    if (abort) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= 8'd0;
                        rsp_nack  <= 1'b1;
                        state     <= S_RESP;
                    end else if (done && !busy) begin
                        if (fetch_pend) begin
                            state <= S_FETCH;
                        end else if (read_bit) begin
                            state <= S_TRIGGER;
                        end else begin
                            state <= S_SETUP;
                        end
                    end
                end
                S_SETUP: begin
                    if (done) begin
                        state <= S_TRIGGER;
                    end
                end
                S_TRIGGER: begin
                    if (done) begin
                        gcnt  <= '0;
                        state <= S_GUARD;
                    end
                end
                S_GUARD: begin
                    if (gcnt == G_LAST) begin
                        if (read_bit) begin
                            fetch_pend <= 1'b1;
                            state      <= S_POLL;
                        end else begin
                            state <= S_ADVANCE;
                        end
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end
                S_FETCH: begin
                    if (done) begin
                        shreg      <= {shreg[6:0], rdata[CTRL_DATA]};
                        wr_nack    <= rdata[CTRL_DATA];
                        fetch_pend <= 1'b0;
                        state      <= S_ADVANCE;
                    end
                end
                S_ADVANCE: begin
                    if (last_bit) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= (op == OP_READ) ? shreg : 8'd0;
                        rsp_nack  <= (op == OP_WRITE) ? wr_nack : 1'b0;
                        state     <= S_RESP;
                    end else begin
                        bcnt  <= bcnt + 4'd1;
                        state <= S_POLL;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_data  <= 8'd0;
                        rsp_nack  <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    i2c_bus_access u_bus (
        .clock          (clock),
        .clock_areset_n (clock_areset_n),
        .go             (go),
        .is_write       (is_write),
        .addr           (addr),
        .wdata          (wdata),
        .done           (done),
        .rdata          (rdata),
        .m_address      (m_address),
        .m_writedata    (m_writedata),
        .m_read         (m_read),
        .m_write        (m_write),
        .m_readdata     (m_readdata),
        .m_waitrequest  (m_waitrequest)
    );

endmodule

// File: tb/tb_i2c_byte_engine.sv
// tb_i2c_byte_engine: bit-master/slave model plus access-sequence reference.
// Table vectors, random commands, response hold, reset abort, optional timeout.
`timescale 1ns/1ps
module tb_i2c_byte_engine;
    import i2c_pkg::*;

    logic        clock = 1'b0;
    logic        clock_areset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [7:0]  cmd_data = 8'd0;
    logic        cmd_nack = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [7:0]  rsp_data;
    logic        rsp_nack;
    logic        rsp_error;
    logic [3:0]  m_address;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata;
    logic        m_read;
    logic        m_write;
    logic        m_waitrequest;

    i2c_byte_engine #(.GUARD_CYCLES(4), .TIMEOUT_POLLS(8)) dut (
        .clock(clock), .clock_areset_n(clock_areset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .cmd_nack(cmd_nack),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_nack(rsp_nack), .rsp_error(rsp_error),
        .m_address(m_address), .m_writedata(m_writedata), .m_readdata(m_readdata),
        .m_read(m_read), .m_write(m_write), .m_waitrequest(m_waitrequest)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        w;
        logic [3:0]  a;
        logic [31:0] d;
    } acc_t;

    acc_t log_q[$];
    acc_t exp_q[$];
    bit   sda_q[$];
    logic sda_bit;
    int   busy_left;
    bit   force_busy = 1'b0;
    int   busy_polls = 0;
    logic stall_done;

    // Bit master: reads stall exactly one cycle, busy for a few polls after GO.
    always_comb m_waitrequest = m_read && !stall_done;
    always_comb m_readdata = {28'd0, (force_busy || busy_left > 0), 2'b00, sda_bit};

    always @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            stall_done <= 1'b0;
            busy_left  <= 0;
            sda_bit    <= 1'b1;
        end else begin
            stall_done <= m_read && m_waitrequest;
            if ((m_read || m_write) && !m_waitrequest) begin
                if (m_write) begin
                    log_q.push_back('{1'b1, m_address, m_writedata});
                    if (m_address == REG_GO) busy_left <= int'($urandom_range(3, 0));
                end else if (m_address == REG_GO) begin
                    log_q.push_back('{1'b0, REG_GO, 32'd0});
                    busy_left <= int'($urandom_range(3, 0));
                    if (sda_q.size() > 0) sda_bit <= sda_q.pop_front();
                    else sda_bit <= 1'b1;
                end else if (m_readdata[3]) begin
                    busy_polls <= busy_polls + 1;
                    if (busy_left > 0) busy_left <= busy_left - 1;
                end else begin
                    log_q.push_back('{1'b0, REG_CTRL, 32'd0});
                end
            end
        end
    end

    // Avalon rule monitor, sampled mid-cycle.
    logic        p_rd = 1'b0, p_wr = 1'b0, p_wait = 1'b0, p_rst = 1'b0;
    logic [3:0]  p_addr = 4'd0;
    logic [31:0] p_wd = 32'd0;

    always @(negedge clock) begin
        if (clock_areset_n && p_rst) begin
            if ((p_rd || p_wr) && p_wait) begin
                n_cmp++;
                if (m_read !== p_rd || m_write !== p_wr
                    || m_address !== p_addr || m_writedata !== p_wd) begin
                    n_bad++;
                    $display("FAIL stall_hold: got rd%0b wr%0b a%0h d%0h want rd%0b wr%0b a%0h d%0h",
                             m_read, m_write, m_address, m_writedata, p_rd, p_wr, p_addr, p_wd);
                end
            end
            if ((p_rd || p_wr) && !p_wait) begin
                n_cmp++;
                if (m_read || m_write) begin
                    n_bad++;
                    $display("FAIL idle_gap: got strobe 1 want 0 after completed access");
                end
            end
        end
        p_rd = m_read; p_wr = m_write; p_wait = m_waitrequest;
        p_addr = m_address; p_wd = m_writedata; p_rst = clock_areset_n;
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endfunction

    function automatic acc_t rd(input logic [3:0] a);
        rd = '{1'b0, a, 32'd0};
    endfunction

    function automatic acc_t wr(input logic [3:0] a, input logic [31:0] d);
        wr = '{1'b1, a, d};
    endfunction

    function automatic void push_read_bit();
        exp_q.push_back(rd(REG_CTRL));
        exp_q.push_back(rd(REG_GO));
        exp_q.push_back(rd(REG_CTRL));
        exp_q.push_back(rd(REG_CTRL));
    endfunction

    function automatic void push_write_bit(input logic [31:0] v);
        exp_q.push_back(rd(REG_CTRL));
        exp_q.push_back(wr(REG_CTRL, v));
        exp_q.push_back(wr(REG_GO, 32'd0));
    endfunction

    // Expected non-busy access list for one command.
    function automatic void build_exp(input op_e op, input logic [7:0] d, input logic nk);
        exp_q.delete();
        case (op)
            OP_START: push_write_bit(32'h4);
            OP_STOP:  push_write_bit(32'h2);
            OP_WRITE: begin
                for (int i = 7; i >= 0; i--) push_write_bit({31'd0, d[i]});
                push_read_bit();
            end
            default: begin
                for (int i = 0; i < 8; i++) push_read_bit();
                push_write_bit({31'd0, nk});
            end
        endcase
    endfunction

    // Slave behaviour: bits returned on successive read slots, SDA high when absent.
    function automatic void load_slave(input op_e op, input logic [7:0] s, input bit present);
        sda_q.delete();
        if (present) begin
            if (op == OP_WRITE) sda_q.push_back(s[0]);
            if (op == OP_READ) for (int i = 7; i >= 0; i--) sda_q.push_back(s[i]);
        end
    endfunction

    task automatic run_cmd(input string nm, input op_e op, input logic [7:0] d,
                           input logic nk, input logic [7:0] e_data, input logic e_nack,
                           input logic e_err, input int hold, input bit chk_seq);
        int n;
        logic [7:0] h_data;
        logic h_nack;
        int bad_at;
        log_q.delete();
        build_exp(op, d, nk);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_nack = nk;
        n = 0;
        while (!cmd_ready && n < 100) begin @(negedge clock); n++; end
        chk({nm, " accept"}, {31'd0, cmd_ready}, 32'd1);
        if (!cmd_ready) begin cmd_valid = 1'b0; return; end
        @(negedge clock);
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_data = 8'($urandom); cmd_nack = 1'($urandom);
        chk({nm, " busy_ready"}, {31'd0, cmd_ready}, 32'd0);
        n = 0;
        while (!rsp_valid && n < 4000) begin @(negedge clock); n++; end
        chk({nm, " rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
        if (!rsp_valid) return;
        h_data = rsp_data; h_nack = rsp_nack;
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            chk({nm, " hold_valid"}, {31'd0, rsp_valid}, 32'd1);
            chk({nm, " hold_payload"}, {23'd0, rsp_data, rsp_nack}, {23'd0, h_data, h_nack});
            chk({nm, " hold_ready"}, {31'd0, cmd_ready}, 32'd0);
        end
        chk({nm, " rsp_data"}, {24'd0, rsp_data}, {24'd0, e_data});
        chk({nm, " rsp_nack"}, {31'd0, rsp_nack}, {31'd0, e_nack});
        chk({nm, " rsp_error"}, {31'd0, rsp_error}, {31'd0, e_err});
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        chk({nm, " ready_after"}, {31'd0, cmd_ready}, 32'd1);
        chk({nm, " valid_after"}, {31'd0, rsp_valid}, 32'd0);
        if (chk_seq) begin
            n_cmp++;
            bad_at = -1;
            for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
                if (bad_at < 0 && (log_q[i].w !== exp_q[i].w || log_q[i].a !== exp_q[i].a
                                   || log_q[i].d !== exp_q[i].d)) bad_at = i;
            if (bad_at < 0 && log_q.size() != exp_q.size())
                bad_at = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
            if (bad_at >= 0) begin
                n_bad++;
                $display("FAIL %s seq: got %0d accesses, want %0d, first difference at %0d",
                         nm, log_q.size(), exp_q.size(), bad_at);
            end
        end
    endtask

    typedef struct {
        op_e        op;
        logic [7:0] d;
        logic       nk;
        logic [7:0] slave;
        bit         present;
        logic [7:0] e_data;
        logic       e_nack;
        int         hold;
    } vec_t;

    vec_t tv[8];

    initial begin
        #900_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        int n;
        int nwr;
        bit stb;
        op_e rop;
        logic [7:0] rd_d, rs;
        bit rp;
        logic rnk;

        tv[0] = '{OP_START, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 0};
        tv[1] = '{OP_WRITE, 8'hA5, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 0};
        tv[2] = '{OP_WRITE, 8'h50, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 0};
        tv[3] = '{OP_READ,  8'h00, 1'b1, 8'h3C, 1'b1, 8'h3C, 1'b0, 0};
        tv[4] = '{OP_START, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 10};
        tv[5] = '{OP_STOP,  8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 0};
        tv[6] = '{OP_READ,  8'h00, 1'b0, 8'h81, 1'b1, 8'h81, 1'b0, 0};
        tv[7] = '{OP_WRITE, 8'hFF, 1'b0, 8'h01, 1'b1, 8'h00, 1'b1, 0};

        repeat (3) @(negedge clock);
        chk("rst cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst rsp_data", {24'd0, rsp_data}, 32'd0);
        chk("rst rsp_nack", {31'd0, rsp_nack}, 32'd0);
        chk("rst rsp_error", {31'd0, rsp_error}, 32'd0);
        chk("rst m_strobes", {30'd0, m_read, m_write}, 32'd0);
        chk("rst m_address", {28'd0, m_address}, 32'd0);
        chk("rst m_writedata", m_writedata, 32'd0);
        clock_areset_n = 1'b1;
        #1 chk("release ready_low", {31'd0, cmd_ready}, 32'd0);
        @(negedge clock);
        chk("release ready_high", {31'd0, cmd_ready}, 32'd1);

        for (int i = 0; i < 8; i++) begin
            load_slave(tv[i].op, tv[i].slave, tv[i].present);
            run_cmd($sformatf("vec%0d", i), tv[i].op, tv[i].d, tv[i].nk,
                    tv[i].e_data, tv[i].e_nack, 1'b0, tv[i].hold, 1'b1);
        end

        for (int i = 0; i < 14; i++) begin
            rop  = op_e'($urandom_range(3, 0));
            rd_d = 8'($urandom);
            rnk  = 1'($urandom);
            rs   = 8'($urandom);
            rp   = 1'($urandom);
            load_slave(rop, rs, rp);
            run_cmd($sformatf("rnd%0d", i), rop, rd_d, rnk,
                    (rop == OP_READ) ? (rp ? rs : 8'hFF) : 8'h00,
                    (rop == OP_WRITE) ? (rp ? rs[0] : 1'b1) : 1'b0,
                    1'b0, int'($urandom_range(2, 0)), 1'b1);
        end

`ifdef I2C_BYTE_ENGINE_TIMEOUT_EN
        force_busy = 1'b1;
        repeat (20) @(negedge clock);
        busy_polls = 0;
        run_cmd("timeout", OP_START, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b0);
        chk("timeout polls", busy_polls, 32'd8);
        force_busy = 1'b0;
        repeat (20) @(negedge clock);
        load_slave(OP_READ, 8'h96, 1'b1);
        run_cmd("post_timeout", OP_READ, 8'h00, 1'b1, 8'h96, 1'b0, 1'b0, 0, 1'b1);
`endif

        load_slave(OP_WRITE, 8'h00, 1'b1);
        log_q.delete();
        cmd_valid = 1'b1; cmd_op = OP_WRITE; cmd_data = 8'hC3; cmd_nack = 1'b0;
        n = 0;
        while (!cmd_ready && n < 100) begin @(negedge clock); n++; end
        @(negedge clock);
        cmd_valid = 1'b0;
        n = 0;
        stb = 1'b0;
        while (!stb && n < 4000) begin
            @(negedge clock);
            n++;
            nwr = 0;
            foreach (log_q[k]) if (log_q[k].w && log_q[k].a == REG_CTRL) nwr++;
            stb = (nwr >= 4) && (m_read || m_write);
        end
        chk("reset strobe_seen", {31'd0, stb}, 32'd1);
        clock_areset_n = 1'b0;
        #1;
        chk("reset strobes", {30'd0, m_read, m_write}, 32'd0);
        chk("reset cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset m_address", {28'd0, m_address}, 32'd0);
        repeat (2) @(negedge clock);
        sda_q.delete();
        clock_areset_n = 1'b1;
        #1 chk("rerelease ready_low", {31'd0, cmd_ready}, 32'd0);
        @(negedge clock);
        chk("rerelease ready_high", {31'd0, cmd_ready}, 32'd1);
        load_slave(OP_WRITE, 8'h00, 1'b1);
        run_cmd("after_reset", OP_WRITE, 8'h3A, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
